// File: rtl/piso_tx.sv
// piso_tx -- parallel-in serial-out transmitter.
//
// Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out
// one bit per clock on dout, with framing strobes. A new word may be accepted
// on the final bit of the current frame, so frames can stream with no gap.
//
// Parameters:
//   WIDTH      bits per frame (>= 2)
//   MSB_FIRST  1: din[WIDTH-1] leaves first; 0: din[0] leaves first
//   IDLE_LEVEL level driven on dout while no frame is active
//
// Ports:
//   clk         system clock, rising edge
//   clear       synchronous reset, active-low
//   load_valid  upstream offers a word on din
//   load_ready  a word can be accepted this cycle
//   din         parallel word, sampled only on an accepted load
//   dout        serial data
//   dout_valid  dout carries a frame bit this cycle
//   last        dout carries the final bit of the frame
//   busy        frame in progress
//   frames_sent completed-frame count, wraps 255 -> 0
module piso_tx #(
    parameter int   WIDTH      = 4,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    output logic             dout,
    output logic             dout_valid,
    output logic             last,
    output logic             busy,
    output logic [7:0]       frames_sent
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] sr_shift_s;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       frames_r;
    logic             final_bit_s;
    logic             ready_s;
    logic             accept_s;

    // Handshake decode; depends only on registered state plus load_valid.
    always_comb begin
        final_bit_s = (state_r == ST_SHIFT) && (cnt_r == CNT_LAST);
        ready_s     = (state_r == ST_IDLE) || final_bit_s;
        accept_s    = load_valid && ready_s;
    end

    // Shift the register toward whichever end feeds dout, filling with zero.
    always_comb begin
        if (MSB_FIRST) begin
            sr_shift_s = {sr_r[WIDTH-2:0], 1'b0};
        end else begin
            sr_shift_s = {1'b0, sr_r[WIDTH-1:1]};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: a final-bit reload keeps us in SHIFT for zero-gap streaming.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (final_bit_s && !accept_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from registers only.
    always_comb begin
        busy       = 1'b0;
        dout_valid = 1'b0;
        last       = 1'b0;
        load_ready = 1'b1;
        dout       = IDLE_LEVEL;
        case (state_r)
            ST_IDLE: begin
                busy       = 1'b0;
                dout_valid = 1'b0;
                last       = 1'b0;
                load_ready = 1'b1;
                dout       = IDLE_LEVEL;
            end
            ST_SHIFT: begin
                busy       = 1'b1;
                dout_valid = 1'b1;
                last       = (cnt_r == CNT_LAST);
                load_ready = (cnt_r == CNT_LAST);
                if (MSB_FIRST) begin
                    dout = sr_r[WIDTH-1];
                end else begin
                    dout = sr_r[0];
                end
            end
            default: begin
                busy       = 1'b0;
                dout_valid = 1'b0;
                last       = 1'b0;
                load_ready = 1'b1;
                dout       = IDLE_LEVEL;
            end
        endcase
    end

    // Datapath: shift register, bit counter and completed-frame counter.
    always_ff @(posedge clk) begin
        if (!clear) begin
            sr_r     <= '0;
            cnt_r    <= '0;
            frames_r <= 8'd0;
        end else begin
            if (accept_s) begin
                sr_r  <= din;
                cnt_r <= '0;
            end else if (final_bit_s) begin
                // Frame ends without a reload: park the datapath cleanly.
                sr_r  <= '0;
                cnt_r <= '0;
            end else if (state_r == ST_SHIFT) begin
                sr_r  <= sr_shift_s;
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                sr_r  <= sr_r;
                cnt_r <= cnt_r;
            end

            if (final_bit_s) begin
                frames_r <= frames_r + 8'd1;
            end else begin
                frames_r <= frames_r;
            end
        end
    end

    assign frames_sent = frames_r;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx. Two instances (MSB-first and LSB-first)
// receive identical stimulus; each is compared every cycle against a model
// that keeps the bits still to be transmitted as a plain list.
module tb_piso_tx;

    localparam int W = 4;

    logic         clk;
    logic         clear;
    logic         load_valid;
    logic [W-1:0] din;

    logic [1:0] load_ready_s;
    logic [1:0] dout_s;
    logic [1:0] dout_valid_s;
    logic [1:0] last_s;
    logic [1:0] busy_s;
    logic [7:0] frames_s [2];

    int n_checks;
    int n_pass;

    // Model state per instance: pending bits (front = bit on dout now).
    bit pend_bit  [2][0:15];
    bit pend_last [2][0:15];
    int plen      [2];
    int mcount    [2];

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk(clk), .clear(clear), .load_valid(load_valid),
        .load_ready(load_ready_s[0]), .din(din), .dout(dout_s[0]),
        .dout_valid(dout_valid_s[0]), .last(last_s[0]), .busy(busy_s[0]),
        .frames_sent(frames_s[0])
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk(clk), .clear(clear), .load_valid(load_valid),
        .load_ready(load_ready_s[1]), .din(din), .dout(dout_s[1]),
        .dout_valid(dout_valid_s[1]), .last(last_s[1]), .busy(busy_s[1]),
        .frames_sent(frames_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One rising edge as seen by the model for instance k (k=0 MSB-first).
    task automatic model_edge(input int k);
        bit ready;
        bit popped_last;
        if (!clear) begin
            plen[k]   = 0;
            mcount[k] = 0;
        end else begin
            ready = (plen[k] <= 1);
            if (plen[k] > 0) begin
                popped_last = pend_last[k][0];
                for (int j = 0; j < 15; j++) begin
                    pend_bit[k][j]  = pend_bit[k][j+1];
                    pend_last[k][j] = pend_last[k][j+1];
                end
                plen[k] = plen[k] - 1;
                if (popped_last) mcount[k] = (mcount[k] + 1) % 256;
            end
            if (load_valid && ready) begin
                for (int j = 0; j < W; j++) begin
                    pend_bit[k][plen[k]]  = (k == 0) ? din[W-1-j] : din[j];
                    pend_last[k][plen[k]] = (j == W - 1);
                    plen[k] = plen[k] + 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            bit v;
            v = (plen[k] > 0);
            check($sformatf("dout_valid[%0d]", k), 32'(dout_valid_s[k]), 32'(v));
            check($sformatf("busy[%0d]", k), 32'(busy_s[k]), 32'(v));
            check($sformatf("dout[%0d]", k), 32'(dout_s[k]), v ? 32'(pend_bit[k][0]) : 32'd0);
            check($sformatf("last[%0d]", k), 32'(last_s[k]), v ? 32'(pend_last[k][0]) : 32'd0);
            check($sformatf("load_ready[%0d]", k), 32'(load_ready_s[k]), 32'(plen[k] <= 1));
            check($sformatf("frames_sent[%0d]", k), 32'(frames_s[k]), 32'(mcount[k]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare_all();
    endtask

    task automatic drive(input logic c, input logic lv, input logic [W-1:0] d);
        clear      = c;
        load_valid = lv;
        din        = d;
    endtask

    int gaps;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        plen[0] = 0; plen[1] = 0;
        mcount[0] = 0; mcount[1] = 0;
        drive(1'b0, 1'b1, 4'hF);

        // 1: reset held with a load offered
        step();
        step();
        check("rst_ready", 32'(load_ready_s[0]), 32'd1);
        check("rst_frames", 32'(frames_s[0]), 32'd0);
        check("rst_dout", 32'(dout_s[1]), 32'd0);

        // 2: single frame 1011
        drive(1'b1, 1'b1, 4'b1011);
        step();
        check("t2_first_msb", 32'(dout_s[0]), 32'd1);
        check("t2_first_lsb", 32'(dout_s[1]), 32'd1);
        drive(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 5; i++) step();
        check("t2_frames", 32'(frames_s[0]), 32'd1);

        // 3: back-to-back 1100 then 0110
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, (i <= 4) ? 1'b1 : 1'b0, (i < 4) ? 4'b1100 : 4'b0110);
            step();
        end
        check("t3_frames", 32'(frames_s[0]), 32'd3);

        // 4: load pulse mid-frame is ignored
        drive(1'b1, 1'b1, 4'b1011); step();
        drive(1'b1, 1'b0, 4'b1011); step();
        drive(1'b1, 1'b1, 4'b0000); step();
        drive(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) step();
        check("t4_frames", 32'(frames_s[0]), 32'd4);

        // 5: reset during bit 2, then a clean frame
        drive(1'b1, 1'b1, 4'b1011); step();
        drive(1'b1, 1'b0, 4'b1011); step();
        drive(1'b0, 1'b0, 4'b1011); step();
        check("t5_busy", 32'(busy_s[0]), 32'd0);
        check("t5_frames", 32'(frames_s[0]), 32'd0);
        drive(1'b1, 1'b1, 4'b0101); step();
        drive(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 5; i++) step();
        check("t5_frames_after", 32'(frames_s[1]), 32'd1);

        // 6: 256 back-to-back frames from reset wrap the counter, no gaps
        drive(1'b0, 1'b0, 4'b0000); step();
        gaps = 0;
        for (int i = 0; i <= 1024; i++) begin
            drive(1'b1, (i < 1024) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)));
            step();
            if (i < 1024 && (dout_valid_s[0] !== 1'b1 || dout_valid_s[1] !== 1'b1)) gaps = gaps + 1;
            if (i == 1023) check("t6_frames_255", 32'(frames_s[0]), 32'd255);
        end
        check("t6_gaps", 32'(gaps), 32'd0);
        check("t6_wrap", 32'(frames_s[0]), 32'd0);
        check("t6_idle", 32'(dout_valid_s[1]), 32'd0);

        // Random traffic, occasional reset
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 29) != 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
